nes_video_capture: RTL
======================

Name: nes_video_capture

Overview:
- Sits directly downstream of the NES top-level video outputs (RGB, x/y pixel clock, visible).
- Detects each new visible pixel and packs it to RGB565.
- Tags each pixel with start-of-frame, end-of-line and end-of-frame flags.
- Buffers pixels in a small FIFO and presents them on a valid/ready stream for a framebuffer writer or host link.
- Tracks completed frames, dropped frames and overflow so software can detect lost video.

Parameters:
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, minimum 4.
- FRAME_WIDTH, 256: visible pixels per line; x >= FRAME_WIDTH is ignored.
- FRAME_HEIGHT, 240: visible lines per frame; y >= FRAME_HEIGHT is ignored.

Ports:
- i_clk  in  1  system clock (same clock as NES top).
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  capture enable.
- i_video_red  in  8  pixel red.
- i_video_green  in  8  pixel green.
- i_video_blue  in  8  pixel blue.
- i_video_x  in  9  current pixel x.
- i_video_y  in  9  current pixel y.
- i_video_visible  in  1  current pixel is visible.
- o_valid  out  1  stream word available.
- i_ready  in  1  consumer accepts word.
- o_data  out  16  RGB565 = {r[7:3], g[7:2], b[7:3]}.
- o_sof  out  1  word is pixel (0,0).
- o_eol  out  1  word has x == FRAME_WIDTH-1.
- o_eof  out  1  word is (FRAME_WIDTH-1, FRAME_HEIGHT-1).
- o_overflow  out  1  sticky; a pixel was dropped.
- o_frame_count  out  16  frames fully pushed; wraps.
- o_dropped_frames  out  8  frames aborted by overflow; saturates at 255.

Behaviour:
- Reset (asynchronous, active-high): FSM=IDLE, FIFO empty, last_x=last_y=9'h1FF, all outputs 0.
- Stage 1: video inputs registered every cycle.
- Pixel event: registered visible=1 AND (x,y) != (last_x,last_y) AND x<FRAME_WIDTH AND y<FRAME_HEIGHT.
  - last_x/last_y update on every pixel event, in every state.
- FSM states:
  - IDLE: no pushes. i_enable=1 -> WAIT_SOF.
  - WAIT_SOF: discard events until an event at (0,0) -> CAPTURE, and that pixel is pushed.
  - CAPTURE: every event pushes {data, sof, eol, eof}.
    - Push of an eof pixel increments o_frame_count.
    - An event at (0,0) mid-frame (truncated frame) is pushed with sof=1; no counter change.
  - DROP: entered when an event occurs with FIFO full and no pop that cycle.
    - On entry: pixel discarded, o_overflow set, o_dropped_frames incremented (saturating).
    - Remaining pixels of the frame are discarded.
    - Next (0,0) event with room -> CAPTURE, pushing that pixel.
- i_enable=0 in any state -> IDLE next cycle; the current event is not pushed. FIFO contents still drain.
- o_overflow clears only on reset or on the (0,0) push that leaves DROP.
- FIFO:
  - Push and pop in the same cycle when full is legal: both happen, count unchanged.
  - Pop on empty is impossible (o_valid=0).
- Stream:
  - o_data and flags hold stable while o_valid=1 and i_ready=0.
  - Transfer occurs on o_valid & i_ready.
  - First-word latency: pixel presented at edge N -> o_valid=1 after edge N+2 (empty FIFO, show-ahead).
  - Full throughput: one word per cycle.

Optional Feature:
- VIDEO_CAPTURE_CRC_EN
- Defined:
  - Adds output port o_frame_crc (16 bits): CRC-16/CCITT (poly 0x1021, init 0xFFFF) over the o_data words of a frame, high byte first.
  - Accumulated on stream transfers.
  - Seeded on the sof transfer; latched to o_frame_crc on the eof transfer.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package nes_video_pkg:
  - FRAME_WIDTH/FRAME_HEIGHT defaults.
  - Capture FSM state encoding (IDLE, WAIT_SOF, CAPTURE, DROP).
  - RGB565 pack function.
  - CRC polynomial/init constants.
- Sub-module nes_video_fifo: synchronous, 19-bit wide (16 data + 3 flags), show-ahead, with full/empty/count.

Test Plan:
- Reset mid-CAPTURE with 5 words queued -> next cycle o_valid=0, o_overflow=0, o_frame_count=0; no words emerge afterwards.
- Enable, full 256x240 frame, i_ready=1 -> 61440 words.
  - First word sof=1, 240 words eol=1, last word eof=1.
  - o_frame_count=1, o_overflow=0.
- Pixel RGB (0xFF,0x80,0x08) -> o_data=0xFC01. Same x/y held 3 cycles -> exactly one word.
- Enable asserted at (10,3) -> nothing pushed until next (0,0); first word has sof=1.
- i_ready=0 with a full frame streaming:
  - After 16 pushes, o_overflow=1 and o_dropped_frames=1.
  - Release i_ready -> 16 words drain; capture resumes at next (0,0).
  - 300 such frames -> o_dropped_frames=255.
- With VIDEO_CAPTURE_CRC_EN, constant-colour frame 0x0000 -> o_frame_crc equals the bench-model CRC; without the macro, the build has no o_frame_crc port.

Source files
------------

// File: rtl/nes_video_pkg.sv
// Shared types and helpers for the NES video capture block: frame geometry
// defaults, capture FSM encoding, the FIFO word layout, RGB565 packing and CRC-16/CCITT.
package nes_video_pkg;

   localparam int DEFAULT_FRAME_WIDTH  = 256;
   localparam int DEFAULT_FRAME_HEIGHT = 240;
   localparam int DEFAULT_FIFO_DEPTH   = 16;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SOF,
      ST_CAPTURE,
      ST_DROP
   } capture_state_t;

   // One FIFO entry: 16 data bits followed by the three framing flags.
   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eol;
      logic        eof;
   } pixel_word_t;

   localparam int PIXEL_WORD_W = $bits(pixel_word_t);

   function automatic logic [15:0] rgb565(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
      return {r[7:3], g[7:2], b[7:3]};
   endfunction

   // MSB-first over the 16-bit word, which is the same as high byte first.
   function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                              input logic [15:0] word);
      logic [15:0] crc;
      logic        feedback;
      crc = crc_in;
      for (int i = 15; i >= 0; i--) begin
         feedback = crc[15] ^ word[i];
         crc      = {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
      end
      return crc;
   endfunction

endpackage

// File: rtl/nes_video_fifo.sv
// Synchronous show-ahead FIFO for tagged pixel words; the head entry is visible
// on o_data whenever o_empty is low. Push and pop together when full are allowed.
module nes_video_fifo
   import nes_video_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int WIDTH = PIXEL_WORD_W
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int                AW         = $clog2(DEPTH);
   localparam logic [AW:0]       FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign o_full  = (count == FULL_COUNT);
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_data  = mem[rd_ptr];

   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!o_full || do_pop);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/nes_video_capture.sv
// Captures NES video into a tagged RGB565 valid/ready stream with frame/drop tracking.
// Define VIDEO_CAPTURE_CRC_EN to add a per-frame CRC-16/CCITT output (o_frame_crc).
module nes_video_capture
   import nes_video_pkg::*;
#(
   parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
   parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
   parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic [7:0]  i_video_red,
   input  logic [7:0]  i_video_green,
   input  logic [7:0]  i_video_blue,
   input  logic [8:0]  i_video_x,
   input  logic [8:0]  i_video_y,
   input  logic        i_video_visible,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_data,
   output logic        o_sof,
   output logic        o_eol,
   output logic        o_eof,
   output logic        o_overflow,
   output logic [15:0] o_frame_count,
   output logic [7:0]  o_dropped_frames
`ifdef VIDEO_CAPTURE_CRC_EN
   ,
   output logic [15:0] o_frame_crc
`endif
);

   localparam logic [9:0] WIDTH_LIM  = 10'(FRAME_WIDTH);
   localparam logic [9:0] HEIGHT_LIM = 10'(FRAME_HEIGHT);
   localparam logic [8:0] LAST_X     = 9'(FRAME_WIDTH - 1);
   localparam logic [8:0] LAST_Y     = 9'(FRAME_HEIGHT - 1);

   logic [7:0]     s1_red;
   logic [7:0]     s1_green;
   logic [7:0]     s1_blue;
   logic [8:0]     s1_x;
   logic [8:0]     s1_y;
   logic           s1_visible;

   logic [8:0]     last_x;
   logic [8:0]     last_y;

   capture_state_t state;
   capture_state_t state_next;

   logic           pixel_event;
   logic           at_origin;
   logic           do_push;
   logic           enter_drop;
   logic           leave_drop;
   logic           stream_pop;
   logic           fifo_room;
   logic           fifo_full;
   logic           fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_level_unused;
   pixel_word_t    push_word;
   pixel_word_t    head_word;

   // Input stage: the NES outputs are re-registered before any decision is made.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s1_red     <= '0;
         s1_green   <= '0;
         s1_blue    <= '0;
         s1_x       <= '0;
         s1_y       <= '0;
         s1_visible <= 1'b0;
      end else begin
         s1_red     <= i_video_red;
         s1_green   <= i_video_green;
         s1_blue    <= i_video_blue;
         s1_x       <= i_video_x;
         s1_y       <= i_video_y;
         s1_visible <= i_video_visible;
      end
   end

   assign at_origin   = (s1_x == 9'd0) && (s1_y == 9'd0);
   assign pixel_event = s1_visible
                        && ((s1_x != last_x) || (s1_y != last_y))
                        && ({1'b0, s1_x} < WIDTH_LIM)
                        && ({1'b0, s1_y} < HEIGHT_LIM);

   assign push_word.data = rgb565(s1_red, s1_green, s1_blue);
   assign push_word.sof  = at_origin;
   assign push_word.eol  = (s1_x == LAST_X);
   assign push_word.eof  = (s1_x == LAST_X) && (s1_y == LAST_Y);

   assign stream_pop = !fifo_empty && i_ready;
   assign fifo_room  = !fifo_full || stream_pop;

   // Position tracking runs in every state so a held pixel never repeats.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         last_x <= 9'h1FF;
         last_y <= 9'h1FF;
      end else if (pixel_event) begin
         last_x <= s1_x;
         last_y <= s1_y;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_next = state;
      do_push    = 1'b0;
      enter_drop = 1'b0;
      leave_drop = 1'b0;
      if (!i_enable) begin
         state_next = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: state_next = ST_WAIT_SOF;
            ST_WAIT_SOF: begin
               if (pixel_event && at_origin) begin
                  if (fifo_room) begin
                     do_push    = 1'b1;
                     state_next = ST_CAPTURE;
                  end else begin
                     enter_drop = 1'b1;
                     state_next = ST_DROP;
                  end
               end
            end
            ST_CAPTURE: begin
               if (pixel_event) begin
                  if (fifo_room) begin
                     do_push = 1'b1;
                  end else begin
                     enter_drop = 1'b1;
                     state_next = ST_DROP;
                  end
               end
            end
            ST_DROP: begin
               if (pixel_event && at_origin && fifo_room) begin
                  do_push    = 1'b1;
                  leave_drop = 1'b1;
                  state_next = ST_CAPTURE;
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_overflow       <= 1'b0;
         o_dropped_frames <= '0;
         o_frame_count    <= '0;
      end else begin
         if (enter_drop) begin
            o_overflow <= 1'b1;
            if (o_dropped_frames != 8'hFF) o_dropped_frames <= o_dropped_frames + 1'b1;
         end else if (leave_drop) begin
            o_overflow <= 1'b0;
         end
         if (do_push && push_word.eof) o_frame_count <= o_frame_count + 1'b1;
      end
   end

   nes_video_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PIXEL_WORD_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (do_push),
      .i_data  (push_word),
      .i_pop   (stream_pop),
      .o_data  (head_word),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_level_unused)
   );

   // Outputs are forced to zero while idle so stale storage never leaks out.
   assign o_valid = !fifo_empty;
   assign o_data  = o_valid ? head_word.data : 16'h0000;
   assign o_sof   = o_valid && head_word.sof;
   assign o_eol   = o_valid && head_word.eol;
   assign o_eof   = o_valid && head_word.eof;

`ifdef VIDEO_CAPTURE_CRC_EN
   logic [15:0] crc_acc;
   logic [15:0] crc_next;

   assign crc_next = crc16_word(head_word.sof ? CRC_INIT : crc_acc, head_word.data);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         crc_acc     <= '0;
         o_frame_crc <= '0;
      end else if (stream_pop) begin
         crc_acc <= crc_next;
         if (head_word.eof) o_frame_crc <= crc_next;
      end
   end
`endif

endmodule
